// File: rtl/param_gshare_predictor.sv
// -----------------------------------------------------------------------------
// param_gshare_predictor
//
// Parameterised gshare branch direction predictor. A pattern history table
// (PHT) of 2^INDEX_BITS saturating counters is indexed by the branch PC XORed
// with a global history register (GHR). After reset the table is swept to
// INIT_CTR one entry per cycle; predictions and updates are accepted only once
// the sweep has finished.
//
// Parameters
//   PC_BITS    : width of branch PCs
//   INDEX_BITS : log2 of the number of PHT entries
//   HIST_BITS  : global history length (1..INDEX_BITS)
//   CTR_BITS   : saturating counter width (2..4)
//   INIT_CTR   : value written to every entry by the init sweep
//
// Ports
//   clk_i              : clock, rising edge
//   reset_i            : synchronous active-high reset, restarts the sweep
//   predict_i          : prediction request
//   predict_pc_i       : PC of the branch to predict
//   update_i           : retired-branch update
//   update_pc_i        : PC of the retired branch
//   update_hist_i      : history that was returned with its prediction
//   update_pred_i      : direction originally predicted
//   reality_i          : direction actually taken
//   ready_o            : table initialised, requests are accepted
//   pred_valid_o       : one-cycle strobe, prediction_o/pred_hist_o valid
//   prediction_o       : predicted direction (1 = taken)
//   pred_hist_o        : GHR value used to form the prediction
//   update_count_o     : accepted updates, wraps at 16 bits
//   mispredict_count_o : detected mispredicts, wraps at 16 bits
// -----------------------------------------------------------------------------
module param_gshare_predictor #(
    parameter int PC_BITS    = 16,
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2,
    parameter int INIT_CTR   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  predict_i,
    input  logic [PC_BITS-1:0]    predict_pc_i,
    input  logic                  update_i,
    input  logic [PC_BITS-1:0]    update_pc_i,
    input  logic [HIST_BITS-1:0]  update_hist_i,
    input  logic                  update_pred_i,
    input  logic                  reality_i,
    output logic                  ready_o,
    output logic                  pred_valid_o,
    output logic                  prediction_o,
    output logic [HIST_BITS-1:0]  pred_hist_o,
    output logic [15:0]           update_count_o,
    output logic [15:0]           mispredict_count_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]   CTR_MIN  = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0]   CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_BITS'(INIT_CTR);
    localparam logic [INDEX_BITS-1:0] IDX_LAST = {INDEX_BITS{1'b1}};
    localparam logic [INDEX_BITS-1:0] IDX_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Saturating counter step: up saturates at all-ones, down floors at zero.
    function automatic logic [CTR_BITS-1:0] ctr_step(
        input logic [CTR_BITS-1:0] ctr,
        input logic                up
    );
        logic [CTR_BITS-1:0] res;
        if (up) begin
            if (ctr == CTR_MAX) begin
                res = ctr;
            end else begin
                res = ctr + CTR_ONE;
            end
        end else begin
            if (ctr == CTR_MIN) begin
                res = ctr;
            end else begin
                res = ctr - CTR_ONE;
            end
        end
        return res;
    endfunction

    // Shift one outcome into a history value. Building the HIST_BITS+1 wide
    // concatenation and keeping the low bits also covers HIST_BITS == 1.
    function automatic logic [HIST_BITS-1:0] hist_shift(
        input logic [HIST_BITS-1:0] hist,
        input logic                 outcome
    );
        logic [HIST_BITS:0] wide;
        wide = {hist, outcome};
        return wide[HIST_BITS-1:0];
    endfunction

    // gshare hash: low PC bits XOR zero-extended history.
    function automatic logic [INDEX_BITS-1:0] gshare_idx(
        input logic [PC_BITS-1:0]   pc,
        input logic [HIST_BITS-1:0] hist
    );
        return pc[INDEX_BITS-1:0] ^ INDEX_BITS'(hist);
    endfunction

    // Registers
    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_q, sweep_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic                  ready_q, ready_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  prediction_q, prediction_d;
    logic [HIST_BITS-1:0]  pred_hist_q, pred_hist_d;
    logic [15:0]           upd_count_q, upd_count_d;
    logic [15:0]           mis_count_q, mis_count_d;
    logic [CTR_BITS-1:0]   pht_q [ENTRIES];

    // Combinational helpers
    logic [INDEX_BITS-1:0] pred_idx_s;
    logic [INDEX_BITS-1:0] upd_idx_s;
    logic [CTR_BITS-1:0]   upd_ctr_new_s;
    logic [CTR_BITS-1:0]   pred_ctr_s;
    logic                  pred_bit_s;
    logic                  mispredict_s;
    logic                  wr_en_s;
    logic [INDEX_BITS-1:0] wr_idx_s;
    logic [CTR_BITS-1:0]   wr_data_s;

    // PC bits above the index take no part in the hash.
    generate
        if (PC_BITS > INDEX_BITS) begin : g_unused_pc
            logic unused_pc_bits_s;
            assign unused_pc_bits_s = ^{predict_pc_i[PC_BITS-1:INDEX_BITS],
                                        update_pc_i[PC_BITS-1:INDEX_BITS]};
        end
    endgenerate

    assign pred_idx_s    = gshare_idx(predict_pc_i, ghr_q);
    assign upd_idx_s     = gshare_idx(update_pc_i, update_hist_i);
    assign upd_ctr_new_s = ctr_step(pht_q[upd_idx_s], reality_i);
    assign mispredict_s  = update_i & (update_pred_i ^ reality_i);

    // Prediction read with write-first bypass from a same-index update.
    always_comb begin
        pred_ctr_s = pht_q[pred_idx_s];
        if (update_i && (upd_idx_s == pred_idx_s)) begin
            pred_ctr_s = upd_ctr_new_s;
        end else begin
            pred_ctr_s = pht_q[pred_idx_s];
        end
    end

    assign pred_bit_s = pred_ctr_s[CTR_BITS-1];

    // Next-state logic: init sweep, update/predict handling and GHR recovery.
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        ghr_d        = ghr_q;
        ready_d      = ready_q;
        pred_valid_d = 1'b0;
        prediction_d = prediction_q;
        pred_hist_d  = pred_hist_q;
        upd_count_d  = upd_count_q;
        mis_count_d  = mis_count_q;
        wr_en_s      = 1'b0;
        wr_idx_s     = sweep_q;
        wr_data_s    = CTR_INIT;

        case (state_q)
            ST_INIT: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = sweep_q;
                wr_data_s = CTR_INIT;
                if (sweep_q == IDX_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + IDX_ONE;
                end
            end
            ST_RUN: begin
                if (update_i) begin
                    wr_en_s     = 1'b1;
                    wr_idx_s    = upd_idx_s;
                    wr_data_s   = upd_ctr_new_s;
                    upd_count_d = upd_count_q + 16'd1;
                end else begin
                    wr_en_s = 1'b0;
                end

                if (mispredict_s) begin
                    // Recovery owns the GHR; a concurrent predict is dropped.
                    mis_count_d = mis_count_q + 16'd1;
                    ghr_d       = hist_shift(update_hist_i, reality_i);
                end else if (predict_i) begin
                    pred_valid_d = 1'b1;
                    prediction_d = pred_bit_s;
                    pred_hist_d  = ghr_q;
                    ghr_d        = hist_shift(ghr_q, pred_bit_s);
                end else begin
                    ghr_d = ghr_q;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = {INDEX_BITS{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_INIT;
            sweep_q      <= {INDEX_BITS{1'b0}};
            ghr_q        <= {HIST_BITS{1'b0}};
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
            pred_hist_q  <= {HIST_BITS{1'b0}};
            upd_count_q  <= 16'd0;
            mis_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            ghr_q        <= ghr_d;
            ready_q      <= ready_d;
            pred_valid_q <= pred_valid_d;
            prediction_q <= prediction_d;
            pred_hist_q  <= pred_hist_d;
            upd_count_q  <= upd_count_d;
            mis_count_q  <= mis_count_d;
        end
    end

    // Pattern table storage; contents are re-established by the sweep, so the
    // array itself carries no reset, but writes are blocked during reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s && !reset_i) begin
            pht_q[wr_idx_s] <= wr_data_s;
        end
    end

    assign ready_o            = ready_q;
    assign pred_valid_o       = pred_valid_q;
    assign prediction_o       = prediction_q;
    assign pred_hist_o        = pred_hist_q;
    assign update_count_o     = upd_count_q;
    assign mispredict_count_o = mis_count_q;

endmodule

// File: tb/tb_param_gshare_predictor.sv
module tb_param_gshare_predictor;

    localparam int INIT_CTR = 1;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        predict_i;
    logic [15:0] predict_pc_i;
    logic        update_i;
    logic [15:0] update_pc_i;
    logic [7:0]  update_hist_i;
    logic        update_pred_i;
    logic        reality_i;
    logic        ready_o;
    logic        pred_valid_o;
    logic        prediction_o;
    logic [7:0]  pred_hist_o;
    logic [15:0] update_count_o;
    logic [15:0] mispredict_count_o;

    always #5 clk = ~clk;

    param_gshare_predictor #(
        .PC_BITS(16), .INDEX_BITS(8), .HIST_BITS(8), .CTR_BITS(2), .INIT_CTR(INIT_CTR)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .predict_i(predict_i), .predict_pc_i(predict_pc_i),
        .update_i(update_i), .update_pc_i(update_pc_i), .update_hist_i(update_hist_i),
        .update_pred_i(update_pred_i), .reality_i(reality_i),
        .ready_o(ready_o), .pred_valid_o(pred_valid_o), .prediction_o(prediction_o),
        .pred_hist_o(pred_hist_o), .update_count_o(update_count_o),
        .mispredict_count_o(mispredict_count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_tbl [256];
    logic [7:0] m_ghr;
    int         m_sweep;
    bit         m_run;
    int         m_upd;
    int         m_mis;

    typedef struct packed {
        logic       pred;
        logic [7:0] hist;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_common(input bit exp_pv);
        exp_t e;
        chk("ready", {31'd0, ready_o}, {31'd0, m_run});
        chk("pred_valid", {31'd0, pred_valid_o}, {31'd0, exp_pv});
        chk("update_count", {16'd0, update_count_o}, m_upd & 32'hFFFF);
        chk("mispredict_count", {16'd0, mispredict_count_o}, m_mis & 32'hFFFF);
        if (pred_valid_o === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_prediction", {31'd0, prediction_o}, {31'd0, e.pred});
            chk("sb_pred_hist", {24'd0, pred_hist_o}, {24'd0, e.hist});
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1; predict_i = 1'b0; update_i = 1'b0;
        predict_pc_i = 16'h0; update_pc_i = 16'h0; update_hist_i = 8'h0;
        update_pred_i = 1'b0; reality_i = 1'b0;
        m_run = 1'b0; m_sweep = 0; m_ghr = 8'h00; m_upd = 0; m_mis = 0;
        sb_q.delete();
        @(posedge clk); #1;
        reset_i = 1'b0;
        check_common(1'b0);
        chk("rst_prediction", {31'd0, prediction_o}, 32'd0);
        chk("rst_pred_hist", {24'd0, pred_hist_o}, 32'd0);
    endtask

    // One clock cycle: drive inputs, advance model, compare after the edge.
    task automatic cyc(input bit p, input logic [15:0] ppc, input bit u,
                       input logic [15:0] upc, input logic [7:0] uh,
                       input bit up, input bit r);
        bit         mis;
        bit         pb;
        bit         exp_pv;
        logic [7:0] uidx;
        logic [7:0] pidx;
        int         nc;
        predict_i = p; predict_pc_i = ppc; update_i = u; update_pc_i = upc;
        update_hist_i = uh; update_pred_i = up; reality_i = r;
        exp_pv = 1'b0;
        if (!m_run) begin
            m_tbl[m_sweep] = INIT_CTR;
            if (m_sweep == 255) m_run = 1'b1;
            else m_sweep++;
        end else begin
            mis  = u && (up != r);
            uidx = upc[7:0] ^ uh;
            pidx = ppc[7:0] ^ m_ghr;
            if (u) begin
                nc = m_tbl[uidx] + (r ? 1 : -1);
                if (nc > 3) nc = 3;
                if (nc < 0) nc = 0;
                m_tbl[uidx] = nc;
                m_upd++;
                if (mis) m_mis++;
            end
            if (p && !mis) begin
                pb = (m_tbl[pidx] >= 2);
                sb_q.push_back({pb, m_ghr});
                exp_pv = 1'b1;
                m_ghr = {m_ghr[6:0], pb};
            end
            if (mis) m_ghr = {uh[6:0], r};
        end
        @(posedge clk); #1;
        predict_i = 1'b0; update_i = 1'b0;
        check_common(exp_pv);
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic predict(input logic [15:0] pc);
        cyc(1'b1, pc, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [15:0] pc, input logic [7:0] h, input bit up, input bit r);
        cyc(1'b0, 16'h0, 1'b1, pc, h, up, r);
    endtask

    // Count cycles with ready low after a reset edge, bounded.
    task automatic count_init(input bit junk, output int zeros);
        int guard;
        zeros = 0;
        guard = 0;
        if (ready_o === 1'b0) zeros++;
        while (ready_o !== 1'b1 && guard < 300) begin
            if (junk) cyc(1'b1, 16'h00AA, 1'b1, 16'h00AA, 8'h00, 1'b0, 1'b1);
            else idle();
            if (ready_o === 1'b0) zeros++;
            guard++;
        end
    endtask

    initial begin
        int zeros;

        // Reset and initial sweep
        do_reset();
        count_init(1'b0, zeros);
        chk("ready_low_cycles", zeros, 32'd256);

        // First prediction on a freshly swept table
        predict(16'h00AA);
        chk("p25_prediction", {31'd0, prediction_o}, 32'd0);
        chk("p25_pred_hist", {24'd0, pred_hist_o}, 32'h00);
        predict(16'h0000);
        chk("p25_ghr_zero", {24'd0, pred_hist_o}, 32'h00);

        // Saturating increment via three mispredicting updates
        repeat (3) update(16'h00AA, 8'h00, 1'b0, 1'b1);
        chk("p26_mis_count", {16'd0, mispredict_count_o}, 32'd3);
        chk("p26_upd_count", {16'd0, update_count_o}, 32'd3);
        update(16'h0055, 8'h00, 1'b1, 1'b0);   // recovery to GHR 0
        predict(16'h00AA);
        chk("p26_prediction", {31'd0, prediction_o}, 32'd1);
        chk("p26_pred_hist", {24'd0, pred_hist_o}, 32'h00);

        // Floor at zero on a fresh entry (correct-direction updates)
        repeat (2) update(16'h0033, 8'h00, 1'b0, 1'b0);
        predict(16'h0032);                      // GHR 0x01 -> index 0x33
        chk("p27_prediction", {31'd0, prediction_o}, 32'd0);
        chk("p27_pred_hist", {24'd0, pred_hist_o}, 32'h01);

        // Speculative history then mispredict recovery with dropped predict
        update(16'h0055, 8'h00, 1'b1, 1'b0);   // GHR -> 0x00
        predict(16'h00AA);
        chk("p28_pred1", {31'd0, prediction_o}, 32'd1);
        predict(16'h00AB);
        chk("p28_pred2", {31'd0, prediction_o}, 32'd1);
        chk("p28_hist2", {24'd0, pred_hist_o}, 32'h01);
        predict(16'h0000);
        chk("p28_pred3", {31'd0, prediction_o}, 32'd0);
        chk("p28_hist3", {24'd0, pred_hist_o}, 32'h03);
        predict(16'h0000);
        chk("p28_hist4", {24'd0, pred_hist_o}, 32'h06);
        cyc(1'b1, 16'h0010, 1'b1, 16'h0000, 8'h05, 1'b0, 1'b1);
        chk("p28_dropped", {31'd0, pred_valid_o}, 32'd0);
        predict(16'h0000);
        chk("p28_recovered_hist", {24'd0, pred_hist_o}, 32'h0B);

        // Write-first bypass: GHR is 0x16, 0x56 ^ 0x16 = 0x40
        cyc(1'b1, 16'h0056, 1'b1, 16'h0040, 8'h00, 1'b1, 1'b1);
        chk("p29_bypass", {31'd0, prediction_o}, 32'd1);
        chk("p29_valid", {31'd0, pred_valid_o}, 32'd1);

        // Reset mid-sweep at index 100, with traffic ignored during init
        do_reset();
        repeat (100) idle();
        do_reset();
        count_init(1'b1, zeros);
        chk("p30_ready_low_cycles", zeros, 32'd256);
        chk("p30_no_updates", {16'd0, update_count_o}, 32'd0);

        // Every entry must hold INIT_CTR: +1 with bypass must give taken
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, {8'h00, i[7:0] ^ m_ghr}, 1'b1, {8'h00, i[7:0]}, 8'h00, 1'b1, 1'b1);
        end
        chk("p30_final_updates", {16'd0, update_count_o}, 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
